// File: rtl/cache_arb_pkg.sv
// Shared types and the round-robin pick helper for the cache port arbiter.
// Requester indices are carried as 3-bit values so one helper serves NUM_REQ 2..8.
package cache_arb_pkg;

    localparam int MAX_REQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_DONE  = 2'd2
    } arbState_t;

    // Bits above NUM_REQ are zero-padded, so a modulo-8 search wraps exactly like a modulo-NUM_REQ one.
    function automatic logic [IDX_W-1:0] rr_next(input logic [MAX_REQ-1:0] valid,
                                                  input logic [IDX_W-1:0]   last);
        logic [IDX_W-1:0] idx;
        logic             found;
        rr_next = last;
        found   = 1'b0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            idx = last + IDX_W'(k);
            if (!found && valid[idx]) begin
                rr_next = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin winner selection: first valid requester after lastGrant.
module rr_picker
    import cache_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] reqValid,
    input  logic [IDX_W-1:0]   lastGrant,
    output logic               anyValid,
    output logic [IDX_W-1:0]   winner
);

    logic [MAX_REQ-1:0] validPad;

    always_comb begin
        validPad                = '0;
        validPad[NUM_REQ-1:0]   = reqValid;
    end

    assign anyValid = |reqValid;
    assign winner   = rr_next(validPad, lastGrant);

endmodule

// File: rtl/cache_port_arbiter.sv
// Round-robin front-end serialising NUM_REQ requesters onto the single cache port.
// Optional statistics counters are built when CACHE_ARB_STATS_EN is defined.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ARB_IDLE  | arbitrate; winner sees reqReady and its request is latched
// ARB_ISSUE | enableOut high, latched request held until requestComplete
// ARB_DONE  | enable gap cycle; respValid pulses to the granted requester
module cache_port_arbiter
    import cache_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_LENGTH = 15,
    parameter int DATA_WIDTH  = 32,
    parameter int STAT_WIDTH  = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            reqValid,
    input  logic [NUM_REQ-1:0]            reqWrite,
    input  logic [NUM_REQ*ADDR_LENGTH-1:0] reqAddr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] reqData,
    output logic [NUM_REQ-1:0]            reqReady,
    output logic [NUM_REQ-1:0]            respValid,
    output logic [DATA_WIDTH-1:0]         respData,
    output logic [ADDR_LENGTH-1:0]        addrOut,
    output logic                          enableOut,
    output logic                          writeOut,
    output logic [DATA_WIDTH-1:0]         dataOut,
    input  logic [DATA_WIDTH-1:0]         cacheData,
    input  logic                          requestComplete
`ifdef CACHE_ARB_STATS_EN
    ,
    input  logic                          statClear,
    output logic [NUM_REQ*STAT_WIDTH-1:0] statGrantCount,
    output logic [STAT_WIDTH-1:0]         statBusyCycles
`endif
);

    arbState_t              state;
    arbState_t              nextState;
    logic [IDX_W-1:0]       lastGrant;
    logic [IDX_W-1:0]       winner;
    logic                   anyValid;
    logic                   handshake;
    logic [NUM_REQ-1:0]     grantMask;
    logic [ADDR_LENGTH-1:0] addrSel;
    logic [DATA_WIDTH-1:0]  dataSel;
    logic                   writeSel;
    logic [ADDR_LENGTH-1:0] addrLat;
    logic [DATA_WIDTH-1:0]  dataLat;
    logic                   writeLat;

    rr_picker #(.NUM_REQ(NUM_REQ)) uPicker (
        .reqValid  (reqValid),
        .lastGrant (lastGrant),
        .anyValid  (anyValid),
        .winner    (winner)
    );

    assign handshake = (state == ARB_IDLE) && anyValid;
    assign grantMask = NUM_REQ'(1) << winner;
    assign writeSel  = |(reqWrite & grantMask);

    always_comb begin
        addrSel = '0;
        dataSel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grantMask[i]) begin
                addrSel = reqAddr[i*ADDR_LENGTH +: ADDR_LENGTH];
                dataSel = reqData[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ARB_IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            ARB_IDLE:  if (anyValid) nextState = ARB_ISSUE;
            ARB_ISSUE: if (requestComplete) nextState = ARB_DONE;
            ARB_DONE:  nextState = ARB_IDLE;
            default:   nextState = ARB_IDLE;
        endcase
    end

    // reqReady is gated by reset so a requester held valid through reset sees no accept.
    always_comb begin
        reqReady  = '0;
        respValid = '0;
        enableOut = 1'b0;
        case (state)
            ARB_IDLE:  if (reset && anyValid) reqReady = grantMask;
            ARB_ISSUE: enableOut = 1'b1;
            ARB_DONE:  respValid = NUM_REQ'(1) << lastGrant;
            default:   enableOut = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lastGrant <= IDX_W'(NUM_REQ - 1);
            addrLat   <= '0;
            dataLat   <= '0;
            writeLat  <= 1'b0;
            respData  <= '0;
        end else begin
            if (handshake) begin
                lastGrant <= winner;
                addrLat   <= addrSel;
                dataLat   <= dataSel;
                writeLat  <= writeSel;
            end
            if (state == ARB_ISSUE && requestComplete) begin
                respData <= writeLat ? '0 : cacheData;
            end
        end
    end

    assign addrOut  = addrLat;
    assign dataOut  = dataLat;
    assign writeOut = writeLat;

`ifdef CACHE_ARB_STATS_EN
    logic [STAT_WIDTH-1:0] grantCnt [NUM_REQ];
    logic [STAT_WIDTH-1:0] busyCnt;

    // Clear wins over a same-cycle increment; both counters stick at all-ones.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REQ; i++) grantCnt[i] <= '0;
            busyCnt <= '0;
        end else if (statClear) begin
            for (int i = 0; i < NUM_REQ; i++) grantCnt[i] <= '0;
            busyCnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (handshake && grantMask[i] && grantCnt[i] != {STAT_WIDTH{1'b1}}) begin
                    grantCnt[i] <= grantCnt[i] + 1'b1;
                end
            end
            if (state != ARB_IDLE && busyCnt != {STAT_WIDTH{1'b1}}) begin
                busyCnt <= busyCnt + 1'b1;
            end
        end
    end

    always_comb begin
        statGrantCount = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            statGrantCount[i*STAT_WIDTH +: STAT_WIDTH] = grantCnt[i];
        end
    end

    assign statBusyCycles = busyCnt;
`endif

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed bench for cache_port_arbiter with a transaction-level reference model.
module tb_cache_port_arbiter;

    localparam int NR = 4;
    localparam int AL = 15;
    localparam int DW = 32;
    localparam int SW = 16;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic [NR-1:0]    reqValid;
    logic [NR-1:0]    reqWrite;
    logic [NR*AL-1:0] reqAddr;
    logic [NR*DW-1:0] reqData;
    logic [NR-1:0]    reqReady;
    logic [NR-1:0]    respValid;
    logic [DW-1:0]    respData;
    logic [AL-1:0]    addrOut;
    logic             enableOut;
    logic             writeOut;
    logic [DW-1:0]    dataOut;
    logic [DW-1:0]    cacheData;
    logic             requestComplete;
    logic             autoComplete;
    logic             manualComplete;
`ifdef CACHE_ARB_STATS_EN
    logic             statClear;
    logic [NR*SW-1:0] statGrantCount;
    logic [SW-1:0]    statBusyCycles;
`endif

    assign requestComplete = autoComplete | manualComplete;

    cache_port_arbiter #(
        .NUM_REQ(NR), .ADDR_LENGTH(AL), .DATA_WIDTH(DW), .STAT_WIDTH(SW)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .reqValid        (reqValid),
        .reqWrite        (reqWrite),
        .reqAddr         (reqAddr),
        .reqData         (reqData),
        .reqReady        (reqReady),
        .respValid       (respValid),
        .respData        (respData),
        .addrOut         (addrOut),
        .enableOut       (enableOut),
        .writeOut        (writeOut),
        .dataOut         (dataOut),
        .cacheData       (cacheData),
        .requestComplete (requestComplete)
`ifdef CACHE_ARB_STATS_EN
        ,
        .statClear       (statClear),
        .statGrantCount  (statGrantCount),
        .statBusyCycles  (statBusyCycles)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transaction-level reference: the granted requester (or -1) and whether its result is back.
    int            mGrant = -1;
    bit            mDone  = 1'b0;
    int            mLast  = NR - 1;
    logic [AL-1:0] mAddr  = '0;
    logic          mWrite = 1'b0;
    logic [DW-1:0] mData  = '0;
    logic [DW-1:0] mResp  = '0;

    int            hsLog[$];
    int            hsCyc[$];
    int            respIdxLog[$];
    logic [DW-1:0] respDataLog[$];
    int            enCycles   = 0;
    int            rdy0Cycles = 0;
    int            cyc        = 0;

    function automatic int pick(input logic [NR-1:0] v, input int last);
        for (int k = 1; k <= NR; k++) begin
            if (v[(last + k) % NR]) return (last + k) % NR;
        end
        return -1;
    endfunction

    initial begin
        int            p;
        logic [NR-1:0] expRdy;
        logic [NR-1:0] expResp;
        forever begin
            @(negedge clock);
            cyc++;
            if (!reset) begin
                mGrant = -1; mDone = 1'b0; mLast = NR - 1;
                mAddr = '0; mWrite = 1'b0; mData = '0; mResp = '0;
            end
            p       = pick(reqValid, mLast);
            expRdy  = (reset && mGrant < 0 && p >= 0) ? NR'(1) << p : '0;
            expResp = mDone ? NR'(1) << mGrant : '0;
            chk("reqReady",  64'(reqReady),  64'(expRdy));
            chk("enableOut", 64'(enableOut), 64'(mGrant >= 0 && !mDone));
            chk("respValid", 64'(respValid), 64'(expResp));
            chk("addrOut",   64'(addrOut),   64'(mAddr));
            chk("writeOut",  64'(writeOut),  64'(mWrite));
            chk("dataOut",   64'(dataOut),   64'(mData));
            if (mDone || !reset) chk("respData", 64'(respData), 64'(mResp));

            if (reset) begin
                for (int i = 0; i < NR; i++) begin
                    if (reqValid[i] && reqReady[i]) begin hsLog.push_back(i); hsCyc.push_back(cyc); end
                    if (respValid[i]) begin respIdxLog.push_back(i); respDataLog.push_back(respData); end
                end
                if (enableOut) enCycles++;
                if (reqReady[0]) rdy0Cycles++;

                if (mGrant < 0) begin
                    if (p >= 0) begin
                        mGrant = p; mLast = p;
                        mAddr  = reqAddr[p*AL +: AL];
                        mWrite = reqWrite[p];
                        mData  = reqData[p*DW +: DW];
                    end
                end else if (!mDone) begin
                    if (requestComplete) begin
                        mDone = 1'b1;
                        mResp = mWrite ? '0 : cacheData;
                    end
                end else begin
                    mGrant = -1;
                    mDone  = 1'b0;
                end
            end
        end
    end

    // Cache stand-in: completes cacheLat cycles into each enable window (0 = never).
    int cacheLat = 0;
    int latCnt   = 0;
    initial begin
        autoComplete = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (enableOut && !autoComplete && cacheLat > 0) begin
                latCnt++;
                if (latCnt >= cacheLat) autoComplete = 1'b1;
            end else begin
                autoComplete = 1'b0;
                latCnt       = 0;
            end
        end
    end

    task automatic clearLogs();
        hsLog.delete(); hsCyc.delete(); respIdxLog.delete(); respDataLog.delete();
        enCycles = 0; rdy0Cycles = 0;
    endtask

    task automatic doReset();
        @(posedge clock); #1;
        reset = 1'b0; reqValid = '0;
        @(posedge clock); #1;
        reset = 1'b1;
    endtask

    task automatic waitHs(input int n, input int budget, input string name);
        int c = 0;
        while (hsLog.size() < n && c < budget) begin
            @(posedge clock); #1; c++;
        end
        if (hsLog.size() < n) begin
            checks++; errors++;
            $display("FAIL %s timeout: handshakes %0d required %0d", name, hsLog.size(), n);
        end
    endtask

    task automatic waitResp(input int n, input int budget, input string name);
        int c = 0;
        while (respIdxLog.size() < n && c < budget) begin
            @(posedge clock); #1; c++;
        end
        if (respIdxLog.size() < n) begin
            checks++; errors++;
            $display("FAIL %s timeout: responses %0d required %0d", name, respIdxLog.size(), n);
        end
    endtask

    initial begin
        int expOrder[5] = '{0, 1, 2, 3, 0};
        reqValid = 4'b0001; reqWrite = '0; reqAddr = '0; reqData = '0;
        cacheData = '0; manualComplete = 1'b0;
`ifdef CACHE_ARB_STATS_EN
        statClear = 1'b0;
`endif
        @(posedge clock); #1;
        chk("rst reqReady",  64'(reqReady),  64'h0);
        chk("rst enableOut", 64'(enableOut), 64'h0);
        chk("rst respValid", 64'(respValid), 64'h0);
        chk("rst addrOut",   64'(addrOut),   64'h0);
        chk("rst respData",  64'(respData),  64'h0);
        @(posedge clock); #1;
        reqValid = '0;
        reset    = 1'b1;

        // single read
        clearLogs();
        cacheLat  = 5;
        cacheData = 32'hDEADBEEF;
        reqAddr[0 +: AL] = 15'h0040;
        reqValid  = 4'b0001;
        waitHs(1, 10, "read hs");
        reqValid  = '0;
        chk("read addrOut", 64'(addrOut), 64'h0040);
        waitResp(1, 20, "read resp");
        chk("read ready cycles",  64'(rdy0Cycles),     64'd1);
        chk("read enable cycles", 64'(enCycles),       64'd5);
        chk("read resp idx",      64'(respIdxLog[0]),  64'd0);
        chk("read resp data",     64'(respDataLog[0]), 64'hDEADBEEF);

        // stray completion in IDLE
        cacheLat = 0;
        manualComplete = 1'b1;
        @(posedge clock); #1;
        manualComplete = 1'b0;
        repeat (3) begin @(posedge clock); #1; end
        chk("stray resp count", 64'(respIdxLog.size()), 64'd1);
        chk("stray enableOut",  64'(enableOut),         64'h0);

        // contention with one-cycle ISSUE
        doReset();
        clearLogs();
        cacheLat  = 1;
        cacheData = 32'h0BADF00D;
        for (int i = 0; i < NR; i++) reqAddr[i*AL +: AL] = AL'(16'h0100 + i);
        reqValid = 4'b1111;
        waitHs(5, 40, "rr hs");
        reqValid = '0;
        waitResp(5, 40, "rr resp");
        for (int i = 0; i < 5; i++) chk($sformatf("rr grant %0d", i), 64'(hsLog[i]), 64'(expOrder[i]));
        chk("rr spacing", 64'(hsCyc[1] - hsCyc[0]), 64'd3);

        // write with wrap
        doReset();
        clearLogs();
        cacheLat  = 3;
        cacheData = 32'hCAFEF00D;
        reqWrite  = 4'b1000;
        reqData[0*DW +: DW] = 32'hAAAA5555;
        reqData[3*DW +: DW] = 32'h12345678;
        reqAddr[3*AL +: AL] = 15'h7FFF;
        reqValid  = 4'b1001;
        waitHs(2, 30, "wr hs");
        reqValid  = '0;
        chk("wr first grant",  64'(hsLog[0]),  64'd0);
        chk("wr second grant", 64'(hsLog[1]),  64'd3);
        chk("wr writeOut",     64'(writeOut),  64'h1);
        chk("wr dataOut",      64'(dataOut),   64'h12345678);
        chk("wr addrOut",      64'(addrOut),   64'h7FFF);
        waitResp(2, 30, "wr resp");
        chk("wr read data",    64'(respDataLog[0]), 64'hCAFEF00D);
        chk("wr write data",   64'(respDataLog[1]), 64'h0);

        // reset two cycles into ISSUE
        clearLogs();
        reqWrite = '0;
        cacheLat = 10;
        reqValid = 4'b0100;
        waitHs(1, 10, "mid hs");
        reqValid = '0;
        chk("mid grant", 64'(hsLog[0]), 64'd2);
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        chk("mid enableOut", 64'(enableOut), 64'h0);
        chk("mid respValid", 64'(respValid), 64'h0);
        @(posedge clock); #1;
        reset = 1'b1;
        repeat (12) begin @(posedge clock); #1; end
        chk("mid no resp", 64'(respIdxLog.size()), 64'd0);
        clearLogs();
        cacheLat = 2;
        reqValid = 4'b1101;
        waitHs(1, 10, "post hs");
        reqValid = '0;
        chk("post grant", 64'(hsLog[0]), 64'd0);
        waitResp(1, 20, "post resp");

`ifdef CACHE_ARB_STATS_EN
        doReset();
        clearLogs();
        cacheLat = 4;
        reqValid = 4'b0001;
        waitHs(3, 40, "stat hs");
        reqValid = '0;
        waitResp(3, 40, "stat resp");
        @(posedge clock); #1;
        chk("stat busy",   64'(statBusyCycles),        64'd15);
        chk("stat grant0", 64'(statGrantCount[0 +: SW]), 64'd3);
        chk("stat grant1", 64'(statGrantCount[SW +: SW]), 64'd0);
        statClear = 1'b1;
        @(posedge clock); #1;
        statClear = 1'b0;
        chk("stat clr busy",  64'(statBusyCycles), 64'd0);
        chk("stat clr grant", 64'(statGrantCount), 64'd0);
`endif

        repeat (2) begin @(posedge clock); #1; end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
